// File: rtl/cpu_pkg.sv
// Shared CPU constants and the fetch-stage state encoding.
package cpu_pkg;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 16;
    localparam logic [ADDR_W-1:0] RESET_VECTOR = 16'h0000;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_out_reg.sv
// One-entry instruction slot between fetch and decode: load, hold under stall, flush on redirect.
module fetch_out_reg #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              flush,
    input  logic              stall,
    input  logic [DATA_W-1:0] load_data,
    input  logic [ADDR_W-1:0] load_pc,
    output logic              slot_free,
    output logic              instr_valid,
    output logic [DATA_W-1:0] instr_out,
    output logic [ADDR_W-1:0] instr_pc
);

    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [ADDR_W-1:0] pc_q, pc_d;

    // The slot can take a new word if it is empty or decode is consuming it this cycle.
    assign slot_free = ~valid_q | ~stall;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        pc_d    = pc_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (load) begin
            valid_d = 1'b1;
            data_d  = load_data;
            pc_d    = load_pc;
        end else if (slot_free) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            pc_q    <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            pc_q    <= pc_d;
        end
    end

    assign instr_valid = valid_q;
    assign instr_out   = data_q;
    assign instr_pc    = pc_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Program counter, fetch FSM and instruction-memory request logic feeding a one-entry
// decode slot; branch redirects flush buffered and in-flight wrong-path fetches.
module instr_fetch_unit #(
    parameter int                ADDR_W       = cpu_pkg::ADDR_W,
    parameter int                DATA_W       = cpu_pkg::DATA_W,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = cpu_pkg::RESET_VECTOR
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic              stall,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic              instr_valid,
    output logic [DATA_W-1:0] instr_out,
    output logic [ADDR_W-1:0] instr_pc
);

    import cpu_pkg::*;

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] req_addr_q, req_addr_d;
    logic              pending_q, pending_d;

    logic              slot_free;
    logic              req_c;
    logic [ADDR_W-1:0] addr_c;
    logic              ack_taken;
    logic              load;

    // An outstanding request keeps its captured address even after the PC is redirected.
    always_comb begin
        req_c  = 1'b0;
        addr_c = pending_q ? req_addr_q : pc_q;
        unique case (state_q)
            FETCH:   req_c = slot_free | pending_q;
            DRAIN:   req_c = 1'b1;
            default: req_c = 1'b0;
        endcase
    end

    // Wrong-path data in DRAIN is dropped, so that ack never waits on the slot.
    always_comb begin
        ack_taken = 1'b0;
        unique case (state_q)
            FETCH:   ack_taken = req_c & imem_ack & slot_free;
            DRAIN:   ack_taken = imem_ack;
            default: ack_taken = 1'b0;
        endcase
    end

    assign load = (state_q == FETCH) & ack_taken & ~branch_taken;

    always_comb begin
        pending_d  = req_c & ~ack_taken;
        req_addr_d = addr_c;
        pc_d       = pc_q;
        state_d    = state_q;

        if (branch_taken) begin
            pc_d = branch_target;
        end else if (load) begin
            pc_d = pc_q + ADDR_W'(1);
        end

        if (state_q == BOOT) begin
            state_d = FETCH;
        end else if ((state_q == DRAIN || branch_taken) && pending_d) begin
            state_d = DRAIN;
        end else begin
            state_d = FETCH;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= BOOT;
            pc_q       <= RESET_VECTOR;
            req_addr_q <= RESET_VECTOR;
            pending_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_addr_q <= req_addr_d;
            pending_q  <= pending_d;
        end
    end

    assign imem_req  = req_c;
    assign imem_addr = addr_c;

    fetch_out_reg #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_out (
        .clk         (clk),
        .rst         (rst),
        .load        (load),
        .flush       (branch_taken),
        .stall       (stall),
        .load_data   (imem_rdata),
        .load_pc     (pc_q),
        .slot_free   (slot_free),
        .instr_valid (instr_valid),
        .instr_out   (instr_out),
        .instr_pc    (instr_pc)
    );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed timing checks plus a random run scored against
// a program-order model of the instruction stream seen by decode.
module tb_instr_fetch_unit;

    localparam int AW = 16;
    localparam int DW = 16;
    localparam logic [AW-1:0] RV = cpu_pkg::RESET_VECTOR;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          branch_taken = 1'b0;
    logic [AW-1:0] branch_target = '0;
    logic          stall = 1'b0;
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic          imem_ack = 1'b0;
    logic [DW-1:0] imem_rdata;
    logic          instr_valid;
    logic [DW-1:0] instr_out;
    logic [AW-1:0] instr_pc;

    always #10 clk = ~clk;

    instr_fetch_unit #(
        .ADDR_W       (AW),
        .DATA_W       (DW),
        .RESET_VECTOR (RV)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .stall         (stall),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .instr_valid   (instr_valid),
        .instr_out     (instr_out),
        .instr_pc      (instr_pc)
    );

    // Memory contents are a fixed scramble of the address.
    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
        return {a[7:0], a[15:8]} ^ 16'hC35A;
    endfunction

    assign imem_rdata = mem_word(imem_addr);

    typedef struct {
        int            cyc;
        logic [AW-1:0] tgt;
    } redir_t;

    redir_t        redir_q[$];
    int            total = 0;
    int            bad = 0;
    int            cyc = 0;
    int            n_consumed = 0;
    int            wait_lo = 0;
    int            wait_hi = 0;
    int            mem_cnt = 0;
    logic          mem_prev_req = 1'b0;
    logic          mem_prev_ack = 1'b0;
    logic          force_ack = 1'b0;
    logic          h_req = 1'b0;
    logic          h_ack = 1'b0;
    logic [AW-1:0] h_addr = '0;
    logic [AW-1:0] exp_pc = RV;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock of stimulus; the memory answers after the DUT's request has settled.
    task automatic step(input logic st, input logic br, input logic [AW-1:0] tgt);
        @(negedge clk);
        cyc++;
        stall         = st;
        branch_taken  = br;
        branch_target = tgt;
        if (br) redir_q.push_back(redir_t'{cyc, tgt});
        #1;
        if (imem_req) begin
            if (!mem_prev_req || mem_prev_ack) mem_cnt = int'($urandom_range(wait_hi, wait_lo));
            else if (mem_cnt > 0) mem_cnt--;
        end
        imem_ack     = force_ack | (imem_req && mem_cnt == 0);
        mem_prev_req = imem_req;
        mem_prev_ack = imem_ack;
    endtask

    // Reset, then 0-wait fetching with a 3-cycle stall while instr_pc=5 is presented.
    task automatic reset_and_start(input logic late_ack);
        logic          e_req;
        logic          e_valid;
        logic [AW-1:0] e_addr;
        logic [AW-1:0] e_ipc;
        @(negedge clk);
        rst           = 1'b1;
        stall         = 1'b0;
        branch_taken  = 1'b0;
        imem_ack      = late_ack;
        force_ack     = late_ack;
        mem_prev_req  = 1'b0;
        mem_prev_ack  = 1'b0;
        wait_lo       = 0;
        wait_hi       = 0;
        redir_q.push_back(redir_t'{cyc, RV});
        @(negedge clk);
        #1;
        chk("rst_req", imem_req, 1'b0);
        chk("rst_addr", imem_addr, RV);
        chk("rst_valid", instr_valid, 1'b0);
        chk("rst_out", instr_out, 0);
        chk("rst_pc", instr_pc, 0);
        @(posedge clk);
        #2 rst = 1'b0;
        for (int k = 0; k < 12; k++) begin
            if (k == 11) begin
                wait_lo = 2;
                wait_hi = 2;
            end
            step((k >= 7 && k <= 9), 1'b0, '0);
            force_ack = 1'b0;
            e_req   = (k >= 1 && k <= 6) || k >= 10;
            e_addr  = (k <= 6) ? AW'(k - 1) : ((k == 10) ? AW'(6) : AW'(7));
            e_valid = (k >= 2);
            e_ipc   = (k <= 6) ? AW'(k - 2) : ((k <= 10) ? AW'(5) : AW'(6));
            chk("start_req", imem_req, e_req);
            if (e_req) chk("start_addr", imem_addr, e_addr);
            chk("start_valid", instr_valid, e_valid);
            if (e_valid) chk("start_ipc", instr_pc, e_ipc);
            if (k >= 7 && k <= 9) chk("stall_out", instr_out, mem_word(16'd5));
        end
    endtask

    // Monitor: every consumption by decode must be the next word of the program stream.
    initial begin
        forever begin
            @(negedge clk);
            #3;
            if (rst) begin
                h_req = 1'b0;
            end else begin
                if (h_req && !h_ack) begin
                    chk("req_hold", imem_req, 1'b1);
                    chk("addr_hold", imem_addr, h_addr);
                end
                h_req  = imem_req;
                h_ack  = imem_ack;
                h_addr = imem_addr;
                if (instr_valid && !stall) begin
                    chk("stream_pc", instr_pc, exp_pc);
                    chk("stream_data", instr_out, mem_word(exp_pc));
                    exp_pc = exp_pc + 1'b1;
                    n_consumed++;
                end
            end
            while (redir_q.size() > 0 && redir_q[0].cyc <= cyc) begin
                exp_pc = redir_q[0].tgt;
                void'(redir_q.pop_front());
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic found;
        int   base;

        reset_and_start(1'b0);

        // Redirect to 'h0040 while the 2-wait fetch of address 7 is outstanding.
        step(1'b0, 1'b1, 16'h0040);
        chk("drain_addr_a", imem_addr, 16'd7);
        step(1'b0, 1'b0, '0);
        chk("drain_req", imem_req, 1'b1);
        chk("drain_addr_b", imem_addr, 16'd7);
        chk("drain_valid", instr_valid, 1'b0);
        step(1'b0, 1'b0, '0);
        chk("target_addr", imem_addr, 16'h0040);
        step(1'b0, 1'b0, '0);

        // Redirect to 'h0100 in the cycle the 'h0040 fetch is acknowledged.
        step(1'b0, 1'b1, 16'h0100);
        step(1'b0, 1'b0, '0);
        chk("br_ack_valid", instr_valid, 1'b0);
        chk("br_ack_req", imem_req, 1'b1);
        chk("br_ack_addr", imem_addr, 16'h0100);
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            step(1'b0, 1'b0, '0);
            if (instr_valid) begin
                found = 1'b1;
                chk("br_ack_ipc", instr_pc, 16'h0100);
            end
        end
        if (!found) chk("br_ack_seen", 1'b0, 1'b1);

        // Address wrap from 'hFFFF to 'h0000 with a 0-wait memory.
        wait_lo = 0;
        wait_hi = 0;
        repeat (3) step(1'b0, 1'b0, '0);
        step(1'b0, 1'b1, 16'hFFFF);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, '0);
            chk("wrap_req", imem_req, 1'b1);
            chk("wrap_addr", imem_addr, AW'(16'hFFFF + i));
        end

        // Reset asserted mid-cycle while a 3-wait request is outstanding.
        wait_lo = 3;
        wait_hi = 3;
        found = 1'b0;
        for (int i = 0; i < 8 && !found; i++) begin
            step(1'b0, 1'b0, '0);
            if (imem_req && !imem_ack) found = 1'b1;
        end
        if (!found) chk("pend_seen", 1'b0, 1'b1);
        #4 rst = 1'b1;
        #1;
        chk("async_req", imem_req, 1'b0);
        chk("async_valid", instr_valid, 1'b0);
        reset_and_start(1'b1);

        // Random stall / redirect / wait-state traffic.
        wait_lo = 0;
        wait_hi = 3;
        base = n_consumed;
        for (int i = 0; i < 1500; i++) begin
            logic          st;
            logic          br;
            logic [AW-1:0] tgt;
            st  = ($urandom % 100) < 30;
            br  = ($urandom % 100) < 5;
            tgt = (($urandom % 4) == 0) ? AW'(16'hFFFC + ($urandom % 4)) : AW'($urandom);
            step(st, br, tgt);
        end
        repeat (20) step(1'b0, 1'b0, '0);
        chk("liveness", (n_consumed - base) > 150, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
